// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
// fq_entry_t is the default-width view of one buffered {pc, insn} entry.
package fetch_pkg;

  localparam int FQ_ADDR_W  = 64;
  localparam int FQ_INSN_W  = 32;
  localparam int INSN_BYTES = 4;
  localparam int PC_INC     = INSN_BYTES;

  typedef struct packed {
    logic [FQ_ADDR_W-1:0] pc;
    logic [FQ_INSN_W-1:0] insn;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch queue bus: redirect, imem request/response and decode-side handshake.
// master = fetch queue side, slave = environment (imem, pipeline control, decode).
interface fetch_queue_if #(
  parameter int ADDR_W = 64,
  parameter int INSN_W = 32
);
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              resp_valid;
  logic [INSN_W-1:0] resp_data;
  logic              out_valid;
  logic [ADDR_W-1:0] out_pc;
  logic [INSN_W-1:0] out_insn;
  logic              id_wr_en;

  modport master (
    input  redirect_valid, redirect_pc, req_ready, resp_valid, resp_data, id_wr_en,
    output req_valid, req_addr, out_valid, out_pc, out_insn
  );

  modport slave (
    output redirect_valid, redirect_pc, req_ready, resp_valid, resp_data, id_wr_en,
    input  req_valid, req_addr, out_valid, out_pc, out_insn
  );
endinterface

// File: rtl/fetch_queue_ring.sv
// fq_ring: DEPTH-entry circular buffer with push/pop/clear and a combinational
// head-entry output. DEPTH must be a power of two so pointers wrap naturally.
module fq_ring #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 96,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] head_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head_reg, tail_reg;
  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (clear) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) tail_reg <= tail_reg + 1'b1;
      if (pop)  head_reg <= head_reg + 1'b1;
      count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage is not reset; the head is only observed while count != 0.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[tail_reg] <= push_data;
  end

  assign count     = count_reg;
  assign head_data = mem[head_reg];

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !clear && count_reg == CNT_W'(DEPTH)));

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch buffer ahead of IF/ID: credit-limited imem requests, drop of
// stale responses after redirect. Optional same-cycle bypass: FETCH_QUEUE_BYPASS_EN.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter int              ADDR_W   = 64,
  parameter int              INSN_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.master bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ENT_W = ADDR_W + INSN_W;
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(PC_INC);

  logic [ADDR_W-1:0] fetch_pc_reg, fetch_pc_next;
  logic [ADDR_W-1:0] resp_pc_reg, resp_pc_next;
  logic [CNT_W-1:0]  outstanding_reg, outstanding_next;
  logic [CNT_W-1:0]  drop_cnt_reg, drop_cnt_next;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    credit_used;
  logic [ENT_W-1:0]  head_data;
  logic              req_fire, resp_drop, resp_take, bypass_hit, push, pop;

  assign credit_used   = {1'b0, count} + {1'b0, outstanding_reg};
  assign bus.req_valid = !reset && !bus.redirect_valid
                         && (credit_used < (CNT_W+1)'(DEPTH));
  assign bus.req_addr  = fetch_pc_reg;
  assign req_fire      = bus.req_valid && bus.req_ready;

  // A response in the redirect cycle belongs to the old stream as well.
  assign resp_drop = bus.resp_valid && (drop_cnt_reg != '0 || bus.redirect_valid);
  assign resp_take = bus.resp_valid && !resp_drop;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass_hit = resp_take && (count == '0);
`else
  assign bypass_hit = 1'b0;
`endif

  assign push = resp_take && !(bypass_hit && bus.id_wr_en);
  assign pop  = (count != '0) && bus.id_wr_en && !bus.redirect_valid;

  always_comb begin
    bus.out_valid = 1'b0;
    bus.out_pc    = '0;
    bus.out_insn  = '0;
    if (count != '0) begin
      bus.out_valid = 1'b1;
      {bus.out_pc, bus.out_insn} = head_data;
    end else if (bypass_hit) begin
      bus.out_valid = 1'b1;
      bus.out_pc    = resp_pc_reg;
      bus.out_insn  = bus.resp_data;
    end
  end

  always_comb begin
    fetch_pc_next    = fetch_pc_reg;
    resp_pc_next     = resp_pc_reg;
    drop_cnt_next    = drop_cnt_reg;
    outstanding_next = outstanding_reg + CNT_W'(req_fire) - CNT_W'(bus.resp_valid);
    if (bus.redirect_valid) begin
      // Everything still in flight after this edge is stale.
      fetch_pc_next = bus.redirect_pc;
      resp_pc_next  = bus.redirect_pc;
      drop_cnt_next = outstanding_reg - CNT_W'(bus.resp_valid);
    end else begin
      if (req_fire)  fetch_pc_next = fetch_pc_reg + PC_STEP;
      if (resp_take) resp_pc_next  = resp_pc_reg + PC_STEP;
      if (resp_drop) drop_cnt_next = drop_cnt_reg - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_reg    <= RESET_PC;
      resp_pc_reg     <= RESET_PC;
      outstanding_reg <= '0;
      drop_cnt_reg    <= '0;
    end else begin
      fetch_pc_reg    <= fetch_pc_next;
      resp_pc_reg     <= resp_pc_next;
      outstanding_reg <= outstanding_next;
      drop_cnt_reg    <= drop_cnt_next;
    end
  end

  fq_ring #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_ring (
    .clk       (clk),
    .reset     (reset),
    .clear     (bus.redirect_valid),
    .push      (push),
    .pop       (pop),
    .push_data ({resp_pc_reg, bus.resp_data}),
    .count     (count),
    .head_data (head_data)
  );

endmodule
